// File: rtl/bitwise_logic_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bitwise_logic_arbiter_pkg
//   Shared opcode and requester-ID definitions for the bitwise logic arbiter
//   and its logic unit.
//   No ports: package only.
// ----------------------------------------------------------------------------
package bitwise_logic_arbiter_pkg;

    // Opcode encoding shared by both requesters.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    // Requester IDs, as reported on res_id and held in last_grant.
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam int unsigned DEF_WIDTH = 20;
    localparam int unsigned DEF_CNT_W = 16;

endpackage : bitwise_logic_arbiter_pkg

// File: rtl/bitwise_logic_unit.sv
// ----------------------------------------------------------------------------
// bitwise_logic_unit
//   Purely combinational WIDTH-bit bitwise logic unit.
//   Ports:
//     op  in  2      opcode (AND / OR / XOR / NOT of i0)
//     i0  in  WIDTH  operand 0
//     i1  in  WIDTH  operand 1 (don't-care for NOT)
//     s   out WIDTH  result
// ----------------------------------------------------------------------------
module bitwise_logic_unit
    import bitwise_logic_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;
    logic [WIDTH-1:0] not_s;

    // Each function is its own cell; the opcode only picks one of them.
    assign and_s = i0 & i1;
    assign or_s  = i0 | i1;
    assign xor_s = i0 ^ i1;
    assign not_s = ~i0;

    always_comb begin
        s = and_s;
        case (op_e'(op))
            OP_AND:  s = and_s;
            OP_OR:   s = or_s;
            OP_XOR:  s = xor_s;
            OP_NOT:  s = not_s;
            default: s = and_s;
        endcase
    end

endmodule : bitwise_logic_unit

// File: rtl/bitwise_logic_arbiter.sv
// ----------------------------------------------------------------------------
// bitwise_logic_arbiter
//   Shares one bitwise logic unit between requester A (CPU execute stage) and
//   requester B (auxiliary checksum/mask engine). Round-robin grant on ties,
//   one registered result stage with valid/ready backpressure, ID-tagged
//   results and a wrapping delivered-result counter.
//
//   Handshake: a transfer happens in any cycle where valid and ready are both
//   high. Requesters hold valid/op/operands stable until ready; ready depends
//   combinationally on valid. On the result side the consumer takes the
//   result in any cycle where res_valid and res_ready are both high.
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     a_valid/a_op/a_i0/a_i1, a_ready   requester A
//     b_valid/b_op/b_i0/b_i1, b_ready   requester B
//     res_valid/res_data/res_id, res_ready  result stage
//     res_count             number of delivered results (wraps)
// ----------------------------------------------------------------------------
module bitwise_logic_arbiter
    import bitwise_logic_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_valid,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_i0,
    input  logic [WIDTH-1:0] a_i1,
    output logic             a_ready,

    input  logic             b_valid,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_i0,
    input  logic [WIDTH-1:0] b_i1,
    output logic             b_ready,

    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count
);

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_id_q,    res_id_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             deliver;
    logic             grant_a;
    logic             grant_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_i0;
    logic [WIDTH-1:0] sel_i1;
    logic [WIDTH-1:0] unit_s;

    // The result register frees up in the same cycle it is drained, so a new
    // op can be accepted back-to-back at full rate.
    assign can_accept = !res_valid_q || res_ready;
    assign deliver    = res_valid_q && res_ready;

    // On a tie, the requester that did not win last time gets the grant.
    // last_grant resets to B so the first tie goes to A.
    assign grant_a = !rst && can_accept && a_valid &&
                     (!b_valid || (last_grant_q == ID_B));
    assign grant_b = !rst && can_accept && b_valid &&
                     (!a_valid || (last_grant_q == ID_A));

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Operand mux in front of the single shared unit.
    assign sel_op = grant_b ? b_op : a_op;
    assign sel_i0 = grant_b ? b_i0 : a_i0;
    assign sel_i1 = grant_b ? b_i1 : a_i1;

    bitwise_logic_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op (sel_op),
        .i0 (sel_i0),
        .i1 (sel_i1),
        .s  (unit_s)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        res_count_d  = res_count_q;

        if (deliver) begin
            res_count_d = res_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (grant_a || grant_b) begin
            res_valid_d  = 1'b1;
            res_data_d   = unit_s;
            res_id_d     = grant_b ? ID_B : ID_A;
            last_grant_d = grant_b ? ID_B : ID_A;
        end else if (deliver) begin
            // Drained with nothing new: data keeps its last value.
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= ID_A;
            res_count_q  <= '0;
            last_grant_q <= ID_B;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_count_q  <= res_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;

endmodule : bitwise_logic_arbiter
